// File: rtl/interrupt_example_debounce_pkg.sv
// interrupt_example_debounce_pkg
//
// Shared definitions for the switch debounce block:
//   - debounce_state_e : per-channel FSM state (stable / settling)
//   - DEBOUNCE_CYCLES_DEFAULT, CNT_W_DEFAULT : default hold-off length and
//     counter width (1 ms at 50 MHz in a 16-bit counter)

package interrupt_example_debounce_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } debounce_state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int CNT_W_DEFAULT           = 16;

endpackage

// File: rtl/interrupt_example_debounce_chan.sv
// interrupt_example_debounce_chan
//
// One debounce channel: 2-flop synchronizer, hold-off FSM with counter,
// registered debounced level and (optionally) registered edge pulses.
//
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN adds o_rise / o_fall.
//
// Ports:
//   i_clk        in   system clock, rising edge
//   i_rst_n      in   asynchronous active-low reset
//   i_switch     in   raw asynchronous pin level
//   o_debounced  out  clean, registered level
//   o_rise       out  one-cycle pulse on debounced 0->1 (macro only)
//   o_fall       out  one-cycle pulse on debounced 1->0 (macro only)

module interrupt_example_debounce_chan
    import interrupt_example_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int   CNT_W           = CNT_W_DEFAULT,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_switch,
    output logic o_debounced
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic o_rise,
    output logic o_fall
`endif
);

    // Count value on the edge where the input has differed for the full
    // hold-off; the counter therefore never exceeds this and never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    debounce_state_e r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_debounced;

    debounce_state_e w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic            w_debounced_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= RESET_BIT;
            r_sync2     <= RESET_BIT;
            r_state     <= ST_STABLE;
            r_cnt       <= '0;
            r_debounced <= RESET_BIT;
        end else begin
            r_sync1     <= i_switch;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_debounced <= w_debounced_nxt;
        end
    end

    // Entering SETTLING already counts the first differing edge (cnt=1), so
    // the output flips on the DEBOUNCE_CYCLES-th consecutive differing edge.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_debounced_nxt = r_debounced;
        case (r_state)
            ST_STABLE: begin
                if (r_sync2 != r_debounced) begin
                    w_state_nxt = ST_SETTLING;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLING: begin
                if (r_sync2 == r_debounced) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_debounced_nxt = r_sync2;
                    w_state_nxt     = ST_STABLE;
                    w_cnt_nxt       = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_debounced = r_debounced;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses are registered alongside the new level so they line up with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_debounced_nxt & ~r_debounced;
            r_fall <= ~w_debounced_nxt & r_debounced;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`endif

endmodule

// File: rtl/interrupt_example_switch_debounce.sv
// interrupt_example_switch_debounce
//
// Synchronizes and debounces WIDTH raw switch/button pins before they reach
// the switch PIO in_port. Each bit is an independent
// interrupt_example_debounce_chan instance.
//
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN adds the rise / fall ports.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   switch_in  in   [WIDTH] raw asynchronous pin levels
//   debounced  out  [WIDTH] clean registered levels (to PIO in_port)
//   rise       out  [WIDTH] one-cycle debounced 0->1 pulses (macro only)
//   fall       out  [WIDTH] one-cycle debounced 1->0 pulses (macro only)

module interrupt_example_switch_debounce
    import interrupt_example_debounce_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int               CNT_W           = CNT_W_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] switch_in,
    output logic [WIDTH-1:0] debounced
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    // Parameter legality: the counter must be able to hold DEBOUNCE_CYCLES-1.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("interrupt_example_switch_debounce: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((CNT_W < 1) || ((CNT_W < 31) && ((1 << CNT_W) <= (DEBOUNCE_CYCLES - 1)))) begin : g_bad_cnt_w
        $error("interrupt_example_switch_debounce: CNT_W too small for DEBOUNCE_CYCLES");
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        interrupt_example_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_BIT       (RESET_VALUE[gi])
        ) u_chan (
            .i_clk       (clk),
            .i_rst_n     (reset_n),
            .i_switch    (switch_in[gi]),
            .o_debounced (debounced[gi])
`ifdef SWITCH_DEBOUNCE_EDGE_EN
            ,
            .o_rise      (rise[gi]),
            .o_fall      (fall[gi])
`endif
        );
    end

endmodule

// File: tb/tb_interrupt_example_switch_debounce.sv
// tb_interrupt_example_switch_debounce
//
// Directed scenarios followed by randomized pin activity. A reference model
// built on a sliding window of synchronized samples (the output flips when
// the last DEBOUNCE_CYCLES samples all differ from it) is compared against
// the DUT every cycle, alongside fixed expectations at the key points.

module tb_interrupt_example_switch_debounce;

    localparam int              W  = 8;
    localparam int              D  = 4;
    localparam logic [W-1:0]    RV = 8'h00;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] switch_in;
    logic [W-1:0] debounced;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [W-1:0] rise;
    logic [W-1:0] fall;
`endif

    int checks = 0;
    int errors = 0;

    interrupt_example_switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .RESET_VALUE     (RV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .switch_in (switch_in),
        .debounced (debounced)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        ,
        .rise      (rise),
        .fall      (fall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pins reach the decision point two edges late; the
    // output bit toggles once the last D such samples all disagree with it.
    logic [W-1:0] mP1, mP2, mDeb, mRise, mFall;
    logic [W-1:0] win[$];

    always @(posedge clk or negedge reset_n) begin : model
        logic [W-1:0] s;
        logic [W-1:0] prev;
        logic         allDiff;
        if (!reset_n) begin
            mP1   = RV;
            mP2   = RV;
            mDeb  = RV;
            mRise = '0;
            mFall = '0;
            win   = {};
        end else begin
            s    = mP2;
            mP2  = mP1;
            mP1  = switch_in;
            win.push_back(s);
            if (win.size() > D) void'(win.pop_front());
            prev = mDeb;
            if (win.size() == D) begin
                for (int b = 0; b < W; b++) begin
                    allDiff = 1'b1;
                    for (int k = 0; k < D; k++)
                        if (win[k][b] == prev[b]) allDiff = 1'b0;
                    if (allDiff) mDeb[b] = ~prev[b];
                end
            end
            mRise = mDeb & ~prev;
            mFall = ~mDeb & prev;
        end
    end

    task automatic checkOutput(input string tag);
        checks++;
        assert (debounced === mDeb) else begin
            errors++;
            $error("[TB] FAIL %s debounced observed=%h expected=%h", tag, debounced, mDeb);
        end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        checks++;
        assert (rise === mRise) else begin
            errors++;
            $error("[TB] FAIL %s rise observed=%h expected=%h", tag, rise, mRise);
        end
        checks++;
        assert (fall === mFall) else begin
            errors++;
            $error("[TB] FAIL %s fall observed=%h expected=%h", tag, fall, mFall);
        end
`endif
    endtask

    task automatic expectConst(input string tag, input logic [W-1:0] expDeb,
                               input logic [W-1:0] expRise, input logic [W-1:0] expFall);
        checks++;
        assert (debounced === expDeb) else begin
            errors++;
            $error("[TB] FAIL %s debounced observed=%h expected=%h", tag, debounced, expDeb);
        end
`ifdef SWITCH_DEBOUNCE_EDGE_EN
        checks++;
        assert (rise === expRise) else begin
            errors++;
            $error("[TB] FAIL %s rise observed=%h expected=%h", tag, rise, expRise);
        end
        checks++;
        assert (fall === expFall) else begin
            errors++;
            $error("[TB] FAIL %s fall observed=%h expected=%h", tag, fall, expFall);
        end
`else
        if (expRise != expFall) begin end
`endif
    endtask

    // Advance n cycles, comparing against the model at each falling edge.
    task automatic tick(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] v);
        switch_in = v;
    endtask

    initial begin
        reset_n   = 1'b0;
        switch_in = 8'hFF;
        repeat (3) @(negedge clk);

        // 1: reset with all pins high
        expectConst("rst_hold", 8'h00, 8'h00, 8'h00);
        checkOutput("rst_hold_model");
        reset_n = 1'b1;
        tick(5, "rst_lat");
        expectConst("rst_pre", 8'h00, 8'h00, 8'h00);
        tick(1, "rst_edge");
        expectConst("rst_follow", 8'hFF, 8'hFF, 8'h00);
        tick(1, "rst_after");
        expectConst("rst_pulse_end", 8'hFF, 8'h00, 8'h00);
        applyStimulus(8'h00);
        tick(6, "back_low");
        expectConst("back_low", 8'h00, 8'h00, 8'hFF);
        tick(2, "idle");

        // 2: clean press on bit0
        applyStimulus(8'h01);
        tick(5, "press_lat");
        expectConst("press_pre", 8'h00, 8'h00, 8'h00);
        tick(1, "press_edge");
        expectConst("press", 8'h01, 8'h01, 8'h00);
        tick(2, "press_hold");

        // 3: 3-cycle glitch on bit3 is rejected
        applyStimulus(8'h09);
        tick(3, "glitch_hi");
        applyStimulus(8'h01);
        tick(8, "glitch_lo");
        expectConst("glitch", 8'h01, 8'h00, 8'h00);

        // 4: bounce on bit5, then steady high
        applyStimulus(8'h21); tick(1, "bounce");
        applyStimulus(8'h01); tick(1, "bounce");
        applyStimulus(8'h21); tick(1, "bounce");
        applyStimulus(8'h01); tick(1, "bounce");
        applyStimulus(8'h21);
        tick(5, "bounce_lat");
        expectConst("bounce_pre", 8'h01, 8'h00, 8'h00);
        tick(1, "bounce_edge");
        expectConst("bounce", 8'h21, 8'h20, 8'h00);
        tick(2, "bounce_hold");

        // 5: move to 0x40 then swap bits 1 and 6 simultaneously
        applyStimulus(8'h40);
        tick(6, "to40");
        expectConst("to40", 8'h40, 8'h40, 8'h21);
        tick(2, "hold40");
        applyStimulus(8'h02);
        tick(5, "simul_lat");
        expectConst("simul_pre", 8'h40, 8'h00, 8'h00);
        tick(1, "simul_edge");
        expectConst("simul", 8'h02, 8'h02, 8'h40);
        tick(2, "simul_hold");

        // 6: reset while bit2 is settling (count at 2)
        applyStimulus(8'h06);
        tick(4, "mid_settle");
        expectConst("mid_settle", 8'h02, 8'h00, 8'h00);
        reset_n = 1'b0;
        #1;
        expectConst("async_rst", 8'h00, 8'h00, 8'h00);
        checkOutput("async_rst_model");
        @(negedge clk);
        reset_n = 1'b1;
        tick(5, "rerun_lat");
        expectConst("rerun_pre", 8'h00, 8'h00, 8'h00);
        tick(1, "rerun_edge");
        expectConst("rerun", 8'h06, 8'h06, 8'h00);

        // Randomized pin activity with hold times spanning the filter length
        for (int r = 0; r < 120; r++) begin
            applyStimulus(8'($urandom));
            tick(int'($urandom_range(1, 7)), "random");
        end
        for (int r = 0; r < 40; r++) begin
            applyStimulus(switch_in ^ (8'h1 << $urandom_range(0, 7)));
            tick(int'($urandom_range(2, 6)), "random_bit");
        end
        tick(8, "random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
